key_press_classifier: RTL and testbench
=======================================

Name: key_press_classifier

Overview:
- Sits between a debounce instance and FSM, one instance per button (set, sw, inc).
- Converts one debounced button level into single-cycle event pulses: short press, long press, and auto-repeat while held.
- FSM consumes these pulses directly as inc_short / inc_long / set / sw strobes; runs on the master clock.

Parameters:
CNT_W, 27, width of the hold and repeat counters; must hold LONG_CYCLES and REPEAT_CYCLES.
MIN_CYCLES, 50_000, minimum consecutive high samples for a press to count as short; shorter presses are ignored.
LONG_CYCLES, 50_000_000, consecutive high samples at which a long press is declared; must be > MIN_CYCLES.
REPEAT_CYCLES, 10_000_000, period of repeat pulses after a long press; 0 disables repeat.

Ports:
clk  input  1  master clock (same clock as debounce and FSM)
rst_n  input  1  synchronous, active-low reset
en  input  1  classifier enable; 0 aborts any press and suppresses all pulses
key  input  1  debounced button level, 1 = pressed
short_pulse  output  1  one-cycle pulse on release of a short press
long_pulse  output  1  one-cycle pulse when a hold reaches LONG_CYCLES
repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while held after long_pulse
held  output  1  level: a press is in progress (state PRESS or LONG)

Behaviour:
- Reset: on rst_n=0 at a clk edge: state=WAIT_REL, key_q=1, both counters=0, all outputs 0.
  - key_q is the input register; key is sampled once per cycle into key_q, and all decisions use key_q.
- States:
  - WAIT_REL: wait for the button to be released. Go to IDLE when key_q=0. No pulses in this state.
  - IDLE: when key_q=1, go to PRESS with hold_cnt=1.
  - PRESS, key_q=1: hold_cnt++ (saturating). When hold_cnt becomes LONG_CYCLES: go to LONG, set long_pulse for 1 cycle, rep_cnt=0.
  - PRESS, key_q=0: if hold_cnt >= MIN_CYCLES, set short_pulse for 1 cycle. Go to IDLE, hold_cnt=0.
  - LONG, key_q=1 and REPEAT_CYCLES>0: rep_cnt++. When rep_cnt becomes REPEAT_CYCLES: set repeat_pulse for 1 cycle, rep_cnt=0.
  - LONG, key_q=0: go to IDLE. No short_pulse.
- Press-length rules, in consecutive high samples N of key_q:
  - N < MIN_CYCLES: no pulse.
  - MIN_CYCLES <= N < LONG_CYCLES: short_pulse only.
  - N >= LONG_CYCLES: long_pulse, then floor((N-LONG_CYCLES)/REPEAT_CYCLES) repeat pulses, and no short_pulse.
- Latency:
  - All outputs are registered.
  - Input to key_q: 1 cycle.
  - short_pulse asserts the cycle after the first key_q=0 sample.
  - long_pulse asserts the cycle after the LONG_CYCLES-th high sample.
- Pulse rules: at most one of short_pulse / long_pulse / repeat_pulse is high in any cycle. Each pulse lasts exactly one cycle.
- held is 1 exactly while state is PRESS or LONG (registered).
- en=0: next state=WAIT_REL, counters cleared, all outputs 0 the following cycle. A button still held when en returns produces nothing until it is released and pressed again.
- Reset mid-press: the same lockout applies — no pulses until key_q has been sampled 0.
- Counters saturate at all-ones and never wrap. CNT_W must hold LONG_CYCLES and REPEAT_CYCLES.

Test Plan:
Use overrides MIN=2, LONG=8, REPEAT=4 for all scenarios.
1. Reset with key=0, then key high for 5 cycles, then low -> exactly one short_pulse, 2 cycles after key falls; long_pulse and repeat_pulse stay 0; held=1 for 5 cycles.
2. Key high for 1 cycle -> no pulses. Key high for exactly 7 cycles -> one short_pulse. Key high for exactly 8 cycles -> one long_pulse and no short_pulse on release.
3. Key high for 20 cycles -> long_pulse after the 8th sample, repeat_pulse after samples 12, 16 and 20; no short_pulse on release; no two pulses ever in the same cycle.
4. Key held high through reset release -> no pulses while held. After key goes low then high for 3 cycles -> one short_pulse.
5. Key high for 6 cycles, en=0 at cycle 4, en=1 at cycle 5, then release -> no pulses; held drops 1 cycle after en=0. A later 3-cycle press -> short_pulse.
6. REPEAT_CYCLES=0, key high for 30 cycles -> exactly one long_pulse and no repeat_pulse.

Source files
------------

// File: rtl/key_press_classifier.sv
// key_press_classifier: turns a debounced button level into short/long/repeat event pulses
module key_press_classifier #(
  parameter int CNT_W         = 27,
  parameter int MIN_CYCLES    = 50_000,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic key,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);
  typedef enum logic [1:0] {WAIT_REL, IDLE, PRESS, LONG} state_t;
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_CYCLES);
  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_CYCLES);
  state_t state, state_n;
  logic key_q;
  logic [CNT_W-1:0] hold_cnt, hold_n, rep_cnt, rep_n, hold_inc, rep_inc;
  logic short_n, long_n, repeat_n, held_n;
  assign hold_inc = &hold_cnt ? hold_cnt : hold_cnt + 1'b1;
  assign rep_inc  = &rep_cnt ? rep_cnt : rep_cnt + 1'b1;
  // next state, counters and pulse decisions; en=0 forces the release lockout
  always_comb begin
    state_n  = state;
    hold_n   = hold_cnt;
    rep_n    = rep_cnt;
    short_n  = 1'b0;
    long_n   = 1'b0;
    repeat_n = 1'b0;
    if (!en) begin
      state_n = WAIT_REL;
      hold_n  = '0;
      rep_n   = '0;
    end else begin
      case (state)
        WAIT_REL: if (!key_q) state_n = IDLE;
        IDLE: if (key_q) begin
          state_n = PRESS;
          hold_n  = CNT_W'(1);
        end
        PRESS: if (key_q) begin
          hold_n = hold_inc;
          if (hold_inc == LONG_C) begin
            state_n = LONG;
            long_n  = 1'b1;
            rep_n   = '0;
          end
        end else begin
          short_n = hold_cnt >= MIN_C;
          state_n = IDLE;
          hold_n  = '0;
        end
        LONG: if (!key_q) begin
          state_n = IDLE;
          hold_n  = '0;
          rep_n   = '0;
        end else if (REPEAT_CYCLES != 0) begin
          repeat_n = rep_inc == REP_C;
          rep_n    = repeat_n ? '0 : rep_inc;
        end
        default: state_n = WAIT_REL;
      endcase
    end
    held_n = state_n == PRESS || state_n == LONG;
  end
  // state, input sample and registered outputs; reset starts locked out as if the key were held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= WAIT_REL;
      key_q        <= 1'b1;
      hold_cnt     <= '0;
      rep_cnt      <= '0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      state        <= state_n;
      key_q        <= key;
      hold_cnt     <= hold_n;
      rep_cnt      <= rep_n;
      short_pulse  <= short_n;
      long_pulse   <= long_n;
      repeat_pulse <= repeat_n;
      held         <= held_n;
    end
  end
endmodule

// File: tb/tb_key_press_classifier.sv
// tb_key_press_classifier: directed presses against a run-length model, two repeat settings
module tb_key_press_classifier;
  localparam int MIN = 2, LONG = 8;
  localparam int REP [2] = '{4, 0};
  logic clk = 0, rst_n = 0, en = 1, key = 0;
  logic [1:0] d_short, d_long, d_rep, d_held;
  int checks = 0, errors = 0;
  int m_n [2], m_arm [2], m_kq [2];
  logic [1:0] e_short, e_long, e_rep, e_held;
  logic m_valid = 0;
  int cs [2], cl [2], cr [2], ch;
  int s_s [2], s_l [2], s_r [2];
  always #5 clk = ~clk;
  key_press_classifier #(.CNT_W(8), .MIN_CYCLES(MIN), .LONG_CYCLES(LONG), .REPEAT_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .key(key),
    .short_pulse(d_short[0]), .long_pulse(d_long[0]), .repeat_pulse(d_rep[0]), .held(d_held[0]));
  key_press_classifier #(.CNT_W(8), .MIN_CYCLES(MIN), .LONG_CYCLES(LONG), .REPEAT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .key(key),
    .short_pulse(d_short[1]), .long_pulse(d_long[1]), .repeat_pulse(d_rep[1]), .held(d_held[1]));
  // model: counts consecutive high samples of the delayed key and derives pulses from that run length
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int n, arm, kq;
      logic s, l, r;
      n = m_n[d]; arm = m_arm[d]; kq = m_kq[d];
      s = 0; l = 0; r = 0;
      if (!rst_n) begin
        n = 0; arm = 0; kq = 1;
      end else begin
        if (!en) begin
          n = 0; arm = 0;
        end else if (arm == 0) begin
          arm = (kq == 0) ? 1 : 0;
        end else if (kq == 1) begin
          n = n + 1;
          if (n == LONG) l = 1;
          else if (REP[d] > 0 && n > LONG && (n - LONG) % REP[d] == 0) r = 1;
        end else begin
          s = (n >= MIN && n < LONG);
          n = 0;
        end
        kq = key ? 1 : 0;
      end
      m_n[d] <= n; m_arm[d] <= arm; m_kq[d] <= kq;
      e_short[d] <= s; e_long[d] <= l; e_rep[d] <= r; e_held[d] <= (n > 0);
    end
    m_valid <= 1'b1;
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick(input int cnt);
    repeat (cnt) begin
      @(negedge clk);
      if (m_valid) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("short[%0d]", d), int'(d_short[d]), int'(e_short[d]));
          chk($sformatf("long[%0d]", d), int'(d_long[d]), int'(e_long[d]));
          chk($sformatf("repeat[%0d]", d), int'(d_rep[d]), int'(e_rep[d]));
          chk($sformatf("held[%0d]", d), int'(d_held[d]), int'(e_held[d]));
          chk($sformatf("one_pulse[%0d]", d), int'($countones({d_short[d], d_long[d], d_rep[d]}) <= 1), 1);
          cs[d] += int'(d_short[d]); cl[d] += int'(d_long[d]); cr[d] += int'(d_rep[d]);
        end
        ch += int'(d_held[0]);
      end
    end
  endtask
  task automatic snap();
    for (int d = 0; d < 2; d++) begin
      s_s[d] = cs[d]; s_l[d] = cl[d]; s_r[d] = cr[d];
    end
    ch = 0;
  endtask
  task automatic expect_cnt(input string name, input int d, input int s, input int l, input int r);
    chk({name, "_short"}, cs[d] - s_s[d], s);
    chk({name, "_long"}, cl[d] - s_l[d], l);
    chk({name, "_repeat"}, cr[d] - s_r[d], r);
  endtask
  task automatic press(input int hi, input int lo);
    key = 1; tick(hi);
    key = 0; tick(lo);
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      cs[d] = 0; cl[d] = 0; cr[d] = 0;
    end
    ch = 0;
    tick(3);
    chk("rst_outputs", int'({d_short, d_long, d_rep, d_held}), 0);
    rst_n = 1;
    tick(3);
    snap();
    key = 1; tick(5);
    key = 0; tick(1);
    chk("t1_short_early", int'(d_short[0]), 0);
    tick(1);
    chk("t1_short_at_2", int'(d_short[0]), 1);
    tick(3);
    expect_cnt("t1", 0, 1, 0, 0);
    chk("t1_held_cycles", ch, 5);
    snap();
    press(1, 4);
    expect_cnt("t2_n1", 0, 0, 0, 0);
    snap();
    press(7, 4);
    expect_cnt("t2_n7", 0, 1, 0, 0);
    snap();
    press(8, 4);
    expect_cnt("t2_n8", 0, 0, 1, 0);
    snap();
    press(20, 4);
    expect_cnt("t3_a", 0, 0, 1, 3);
    expect_cnt("t3_b", 1, 0, 1, 0);
    snap();
    key = 1; rst_n = 0; tick(2);
    rst_n = 1; tick(5);
    chk("t4_held_locked", int'(d_held[0]), 0);
    expect_cnt("t4_locked", 0, 0, 0, 0);
    key = 0; tick(2);
    snap();
    press(3, 4);
    expect_cnt("t4_after", 0, 1, 0, 0);
    snap();
    key = 1; tick(3);
    chk("t5_held_before", int'(d_held[0]), 1);
    en = 0; tick(1);
    chk("t5_held_dropped", int'(d_held[0]), 0);
    en = 1; tick(2);
    key = 0; tick(4);
    expect_cnt("t5_aborted", 0, 0, 0, 0);
    snap();
    press(3, 4);
    expect_cnt("t5_after", 0, 1, 0, 0);
    snap();
    press(30, 4);
    expect_cnt("t6_a", 0, 0, 1, 5);
    expect_cnt("t6_b", 1, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
